// File: rtl/subleq_dump_unit_pkg.sv
// Shared types for the subleq dump unit: FSM state codes (also the debug
// encoding), dump cause codes and the header tag.
package subleq_dump_unit_pkg;

    typedef enum logic [2:0] {
        DBG_IDLE      = 3'd0,
        DBG_HDR_CAUSE = 3'd1,
        DBG_HDR_PC    = 3'd2,
        DBG_READ      = 3'd3,
        DBG_WAIT_MEM  = 3'd4,
        DBG_DRAIN     = 3'd5,
        DBG_DONE      = 3'd6
    } dump_state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t     CAUSE_NONE   = 2'd0;
    localparam cause_t     CAUSE_MANUAL = 2'd1;
    localparam cause_t     CAUSE_BP     = 2'd2;
    localparam cause_t     CAUSE_HALT   = 2'd3;
    localparam logic [3:0] HDR_TAG      = 4'hD;

    // Simultaneous triggers collapse into one dump carrying the strongest cause.
    function automatic cause_t pick_cause(input logic halt, input logic bp, input logic manual);
        if (halt)        return CAUSE_HALT;
        else if (bp)     return CAUSE_BP;
        else if (manual) return CAUSE_MANUAL;
        else             return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/subleq_dump_unit_if.sv
// Memory read port and output word channel of the dump unit.
// mem: req/addr are held from READ until the single-cycle mem_ack, data valid on the ack cycle.
// out: a word moves on a clock edge where out_req && out_ack; out_data is the stable FIFO head.
interface subleq_dump_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic                 mem_req;
    logic                 mem_load;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 out_req;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_ack;

    modport master (
        output mem_req, mem_load, mem_addr, out_req, out_data,
        input  mem_ack, mem_data, out_ack
    );

    modport slave (
        input  mem_req, mem_load, mem_addr, out_req, out_data,
        output mem_ack, mem_data, out_ack
    );
endinterface

// File: rtl/subleq_dump_unit_fifo.sv
// Small synchronous FIFO (power-of-two depth) with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = store[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                store[wptr] <= wdata;
                wptr        <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/subleq_dump_unit.sv
// On halt edge, PC breakpoint or manual request, freezes the subleq CPU and
// streams a cause/PC header plus an inclusive memory window to the output channel.
module subleq_dump_unit
    import subleq_dump_unit_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_BP     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        cpu_halt,
    input  logic                        cpu_fetch,
    input  logic [WORD_SIZE-1:0]        cpu_pc,
    output logic                        cpu_stall,
    input  logic                        dump_go,
    input  logic [WORD_SIZE-1:0]        dump_start,
    input  logic [WORD_SIZE-1:0]        dump_end,
    input  logic [NUM_BP*WORD_SIZE-1:0] bp_addr,
    input  logic [NUM_BP-1:0]           bp_en,
    subleq_dump_unit_if.master          bus,
    output logic                        busy,
    output logic                        done,
    output dump_state_t                 dbg_state
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    dump_state_t          state;
    dump_state_t          state_next;
    logic                 halt_prev;
    cause_t               cause_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] end_q;

    logic                 bp_hit;
    logic                 halt_edge;
    logic                 trig;
    logic                 take_trig;
    logic                 addr_step;
    logic                 mem_req;
    logic                 fifo_push;
    logic [WORD_SIZE-1:0] fifo_wdata;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 out_req;

    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (cpu_pc == bp_addr[i*WORD_SIZE +: WORD_SIZE])) begin
                bp_hit = 1'b1;
            end
        end
        bp_hit = bp_hit && cpu_fetch;
    end

    assign halt_edge = cpu_halt && !halt_prev;
    assign trig      = halt_edge || bp_hit || dump_go;

    // The breakpoint term is combinational so the fetch strobe cycle is already frozen.
    assign cpu_stall = (state != DBG_IDLE) || bp_hit;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        take_trig  = 1'b0;
        addr_step  = 1'b0;
        mem_req    = 1'b0;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            DBG_IDLE: begin
                busy = 1'b0;
                if (trig) begin
                    take_trig  = 1'b1;
                    state_next = DBG_HDR_CAUSE;
                end
            end
            DBG_HDR_CAUSE: begin
                fifo_wdata = {HDR_TAG, {(WORD_SIZE-6){1'b0}}, cause_q};
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    state_next = DBG_HDR_PC;
                end
            end
            DBG_HDR_PC: begin
                fifo_wdata = pc_q;
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    state_next = (end_q < addr_q) ? DBG_DRAIN : DBG_READ;
                end
            end
            DBG_READ: begin
                // Only pushes come from this FSM, so a free slot now stays free until the ack.
                if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
                    mem_req    = 1'b1;
                    state_next = DBG_WAIT_MEM;
                end
            end
            DBG_WAIT_MEM: begin
                mem_req    = 1'b1;
                fifo_wdata = bus.mem_data;
                if (bus.mem_ack) begin
                    fifo_push = 1'b1;
                    if (addr_q == end_q) begin
                        state_next = DBG_DRAIN;
                    end else begin
                        addr_step  = 1'b1;
                        state_next = DBG_READ;
                    end
                end
            end
            DBG_DRAIN: begin
                if (fifo_empty) begin
                    state_next = DBG_DONE;
                end
            end
            DBG_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = DBG_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = DBG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= DBG_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            halt_prev <= 1'b0;
            cause_q   <= CAUSE_NONE;
            pc_q      <= '0;
            addr_q    <= '0;
            end_q     <= '0;
        end else begin
            halt_prev <= cpu_halt;
            if (take_trig) begin
                cause_q <= pick_cause(halt_edge, bp_hit, dump_go);
                pc_q    <= cpu_pc;
                addr_q  <= dump_start;
                end_q   <= dump_end;
            end else if (addr_step) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign out_req      = !fifo_empty;
    assign fifo_pop     = out_req && bus.out_ack;
    assign bus.out_req  = out_req;
    assign bus.mem_req  = mem_req;
    assign bus.mem_load = mem_req;
    assign bus.mem_addr = addr_q;

    sync_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (areset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_subleq_dump_unit.sv
// Bench for subleq_dump_unit: random memory latency and output backpressure,
// expected dump streams pushed into a queue and popped by the output monitor.
module tb_subleq_dump_unit;
    localparam int W  = 16;
    localparam int NB = 2;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          cpu_halt;
    logic          cpu_fetch;
    logic [W-1:0]  cpu_pc;
    logic          cpu_stall;
    logic          dump_go;
    logic [W-1:0]  dump_start;
    logic [W-1:0]  dump_end;
    logic [NB*W-1:0] bp_addr;
    logic [NB-1:0] bp_en;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    subleq_dump_unit_if #(.WORD_SIZE(W)) sif ();

    subleq_dump_unit #(
        .WORD_SIZE  (W),
        .NUM_BP     (NB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .cpu_halt   (cpu_halt),
        .cpu_fetch  (cpu_fetch),
        .cpu_pc     (cpu_pc),
        .cpu_stall  (cpu_stall),
        .dump_go    (dump_go),
        .dump_start (dump_start),
        .dump_end   (dump_end),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .bus        (sif),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int req_cycles = 0;
    int ack_cnt  = 0;
    int ack_pct  = 100;
    bit ack_en   = 1'b1;
    bit mem_hold = 1'b0;
    int mem_lat_max = 0;
    logic [W-1:0] seed_mix;
    logic [W-1:0] mem_img [logic [W-1:0]];
    logic [W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 16'd40503) ^ seed_mix;
    endfunction

    // Reference dump: tag+cause, PC, then every word of the inclusive window.
    task automatic expect_dump(input logic [1:0] cause, input logic [W-1:0] pc,
                               input logic [W-1:0] s, input logic [W-1:0] e);
        logic [W:0] a;
        exp_q.push_back({4'hD, 10'b0, cause});
        exp_q.push_back(pc);
        for (a = {1'b0, s}; a <= {1'b0, e}; a++) begin
            exp_q.push_back(mem_val(a[W-1:0]));
        end
    endtask

    // Memory responder: first cycle of a request is READ, ack comes in WAIT_MEM.
    initial begin
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        sif.mem_ack  = 1'b0;
        sif.mem_data = '0;
        forever begin
            @(negedge clk);
            if (sif.mem_ack) begin
                sif.mem_ack = 1'b0;
                seen = 1'b0;
            end
            if (!sif.mem_req) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                lat  = $urandom_range(0, mem_lat_max);
            end else if (!mem_hold) begin
                if (lat == 0) begin
                    sif.mem_ack  = 1'b1;
                    sif.mem_data = mem_val(sif.mem_addr);
                    ack_cnt++;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Output monitor / consumer.
    initial begin
        bit take;
        logic [W-1:0] exp_w;
        sif.out_ack = 1'b0;
        forever begin
            @(negedge clk);
            take = ack_en && ($urandom_range(0, 99) < ack_pct);
            sif.out_ack = take;
            if (sif.out_req && take) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%h required=no word", sif.out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("out_word", {16'h0, sif.out_data}, {16'h0, exp_w});
                end
            end
        end
    end

    // Event watcher: done pulses and memory request cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (sif.mem_req) req_cycles++;
            if (done) begin
                done_cnt++;
                chk("done_busy_low", busy, 1'b0);
                chk("done_fifo_empty", sif.out_req, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] cause, input int slot,
                         input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] pc);
        cpu_pc = pc;
        dump_start = s;
        dump_end = e;
        if (cause == 2'd1) dump_go = 1'b1;
        if (cause == 2'd2) begin
            bp_addr[slot*W +: W] = pc;
            bp_en = NB'(1) << slot;
            cpu_fetch = 1'b1;
            #1;
            chk("bp_stall_same_cycle", cpu_stall, 1'b1);
        end
        if (cause == 2'd3) begin
            cpu_halt = 1'b1;
            dump_go  = 1'b1;
        end
        expect_dump(cause, pc, s, e);
        @(negedge clk);
        dump_go = 1'b0;
        cpu_fetch = 1'b0;
        bp_en = '0;
        chk("trig_busy", busy, 1'b1);
        chk("trig_stall", cpu_stall, 1'b1);
        @(negedge clk);
        chk("trig_out_req", sif.out_req, 1'b1);
    endtask

    task automatic finish_dump(input int budget, input string name);
        int start_cnt;
        int n;
        start_cnt = done_cnt - ((done === 1'b1) ? 1 : 0);
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start_cnt) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no done required=done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - start_cnt, 1);
        chk("stall_released", cpu_stall, 1'b0);
        chk("busy_released", busy, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int len;
        int kind;
        logic [W-1:0] s;
        logic [W-1:0] pc;
        seed_mix = W'($urandom);
        areset = 1'b1;
        cpu_halt = 1'b0;
        cpu_fetch = 1'b0;
        cpu_pc = '0;
        dump_go = 1'b0;
        dump_start = '0;
        dump_end = '0;
        bp_addr = '0;
        bp_en = '0;
        mem_img[16'h0010] = 16'h0001;
        mem_img[16'h0011] = 16'h0002;
        mem_img[16'h0012] = 16'h0003;
        repeat (3) @(negedge clk);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_mem_req", sif.mem_req, 1'b0);
        chk("rst_out_req", sif.out_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_state", dbg_state, 3'd0);
        areset = 1'b0;
        @(negedge clk);

        // Manual dump with fixed memory contents and a consumer that always acks.
        issue(2'd1, 0, 16'h0010, 16'h0012, 16'h0123);
        finish_dump(100, "manual_basic");

        // Breakpoint in slot 1; a disabled matching slot must not stall.
        bp_addr = {16'h0009, 16'h0009};
        bp_en = 2'b00;
        cpu_pc = 16'h0009;
        cpu_fetch = 1'b1;
        #1;
        chk("bp_disabled_no_stall", cpu_stall, 1'b0);
        @(negedge clk);
        cpu_fetch = 1'b0;
        issue(2'd2, 1, 16'h0040, 16'h0041, 16'h0009);
        finish_dump(100, "bp_slot1");
        chk("bp_pc_kept", cpu_pc, 16'h0009);

        // Halt together with manual request gives a single halt dump.
        issue(2'd3, 0, 16'h0050, 16'h0050, 16'h0777);
        finish_dump(100, "halt_dump");
        repeat (5) @(negedge clk);
        chk("halt_no_retrigger", busy, 1'b0);
        cpu_halt = 1'b0;
        @(negedge clk);

        // Backpressure: two headers plus two data words fill the FIFO.
        mem_lat_max = 1;
        ack_en = 1'b0;
        issue(2'd1, 0, 16'h0030, 16'h0037, 16'h0abc);
        base = ack_cnt;
        repeat (20) @(negedge clk);
        chk("bp_fill_acks", ack_cnt - base, FD - 2);
        chk("full_no_mem_req", sif.mem_req, 1'b0);
        chk("full_out_req", sif.out_req, 1'b1);
        ack_en = 1'b1;
        ack_pct = 50;
        finish_dump(300, "backpressure");

        // Empty window: headers only, no memory traffic.
        base = req_cycles;
        issue(2'd1, 0, 16'h0020, 16'h001F, 16'h0042);
        finish_dump(100, "empty_window");
        chk("empty_no_mem_req", req_cycles - base, 0);

        // Window at the top of the address space must terminate.
        ack_pct = 100;
        issue(2'd1, 0, 16'hFFFE, 16'hFFFF, 16'h0055);
        finish_dump(100, "top_window");

        // Reset while waiting on memory aborts the dump.
        mem_hold = 1'b1;
        ack_en = 1'b0;
        base = done_cnt;
        issue(2'd1, 0, 16'h0060, 16'h0065, 16'h0999);
        repeat (3) @(negedge clk);
        chk("in_wait_mem", dbg_state, 3'd4);
        areset = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", sif.mem_req, 1'b0);
        chk("abort_out_req", sif.out_req, 1'b0);
        chk("abort_stall", cpu_stall, 1'b0);
        chk("abort_busy", busy, 1'b0);
        areset = 1'b0;
        exp_q.delete();
        mem_hold = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        chk("abort_no_done", done_cnt - base, 0);
        issue(2'd1, 0, 16'h0060, 16'h0065, 16'h0999);
        finish_dump(200, "after_abort");

        // Randomized dumps.
        for (int it = 0; it < 10; it++) begin
            ack_pct = $urandom_range(30, 100);
            mem_lat_max = $urandom_range(0, 3);
            s = W'($urandom);
            len = $urandom_range(0, 6);
            pc = W'($urandom);
            kind = $urandom_range(1, 2);
            if (len == 0) begin
                issue(2'(kind), $urandom_range(0, NB-1), s, s - 16'd1, pc);
            end else begin
                issue(2'(kind), $urandom_range(0, NB-1), s, s + W'(len - 1), pc);
            end
            finish_dump(400, "random_dump");
        end

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
